// File: rtl/ifu_fetch_ysyx23060136.sv
// rtl/ifu_fetch_ysyx23060136.sv - instruction fetch unit: AXI-lite style read master feeding the IF/ID segment register
//
// Purpose:
//   Fetches one 32-bit instruction at a time from pc and presents the (pc, inst)
//   pair to the IF/ID segment register. At most one read is ever outstanding.
//   A redirect that arrives while a read is in flight lets that read drain and
//   then drops its data.
//
// Configuration macro:
//   IFU_ACCESS_FAULT_EN - when defined, a non-zero IFU_rresp marks the fetched
//                         pair as faulted. A faulted pair is presented as a NOP
//                         with IFU_o_fault=1 and is held until a redirect.
//                         When undefined, IFU_rresp is ignored and IFU_o_fault=0.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   BRANCH_flushIF        redirect request, fetch restarts at BRANCH_target
//   BRANCH_target         redirect pc
//   FORWARD_stallIF       downstream segment register not accepting this cycle
//   IFU_araddr/arvalid/arready         read address channel
//   IFU_rdata/rresp/rvalid/rready      read data channel
//   IFU_o_pc/o_inst/o_valid/o_fault    fetched pair to IF/ID

module ifu_fetch_ysyx23060136 #(
    parameter logic [31:0] PC_RST = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        BRANCH_flushIF,
    input  logic [31:0] BRANCH_target,
    input  logic        FORWARD_stallIF,
    output logic [31:0] IFU_araddr,
    output logic        IFU_arvalid,
    input  logic        IFU_arready,
    input  logic [31:0] IFU_rdata,
    input  logic [1:0]  IFU_rresp,
    input  logic        IFU_rvalid,
    output logic        IFU_rready,
    output logic [31:0] IFU_o_pc,
    output logic [31:0] IFU_o_inst,
    output logic        IFU_o_valid,
    output logic        IFU_o_fault
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_HOLD
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic        r_fault;
    logic        r_discard;
    logic [31:0] r_redirect_pc;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_o_valid;

    state_t      w_next_state;
    logic        w_ar_done;
    logic        w_r_done;
    logic        w_rsp_fault;
    logic        w_drop_rsp;

`ifdef IFU_ACCESS_FAULT_EN
    assign w_rsp_fault = (IFU_rresp != 2'b00);
    assign IFU_o_fault = r_o_valid & r_fault;
`else
    logic w_unused_rresp;
    assign w_rsp_fault    = 1'b0;
    assign w_unused_rresp = ^IFU_rresp;
    assign IFU_o_fault    = 1'b0;
`endif

    assign w_ar_done  = r_arvalid & IFU_arready;
    assign w_r_done   = r_rready & IFU_rvalid;
    // A flush landing on the completion cycle itself also kills the data.
    assign w_drop_rsp = r_discard | BRANCH_flushIF;

    assign IFU_araddr  = r_pc;
    assign IFU_arvalid = r_arvalid;
    assign IFU_rready  = r_rready;
    assign IFU_o_pc    = r_pc;
    assign IFU_o_inst  = r_inst;
    assign IFU_o_valid = r_o_valid;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: w_next_state = S_AR;
            S_AR: begin
                if (w_ar_done) begin
                    w_next_state = S_R;
                end
            end
            S_R: begin
                if (w_r_done) begin
                    w_next_state = w_drop_rsp ? S_AR : S_HOLD;
                end
            end
            S_HOLD: begin
                // A faulted pair never drains on its own; only a redirect leaves.
                if (BRANCH_flushIF) begin
                    w_next_state = S_AR;
                end else if (!r_fault && !FORWARD_stallIF) begin
                    w_next_state = S_AR;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= PC_RST;
            r_inst        <= NOP;
            r_fault       <= 1'b0;
            r_discard     <= 1'b0;
            r_redirect_pc <= PC_RST;
            r_arvalid     <= 1'b0;
            r_rready      <= 1'b0;
            r_o_valid     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_arvalid <= (w_next_state == S_AR);
            r_rready  <= (w_next_state == S_R);
            r_o_valid <= (w_next_state == S_HOLD);

            case (r_state)
                S_IDLE: begin
                    if (BRANCH_flushIF) begin
                        r_pc <= BRANCH_target;
                    end
                end
                S_AR: begin
                    // Address must stay stable while arvalid is up, so the
                    // redirect is parked until the read drains.
                    if (BRANCH_flushIF) begin
                        r_discard     <= 1'b1;
                        r_redirect_pc <= BRANCH_target;
                    end
                end
                S_R: begin
                    if (w_r_done) begin
                        if (w_drop_rsp) begin
                            r_pc          <= BRANCH_flushIF ? BRANCH_target : r_redirect_pc;
                            r_redirect_pc <= BRANCH_flushIF ? BRANCH_target : r_redirect_pc;
                            r_discard     <= 1'b0;
                        end else begin
                            r_inst  <= w_rsp_fault ? NOP : IFU_rdata;
                            r_fault <= w_rsp_fault;
                        end
                    end else if (BRANCH_flushIF) begin
                        r_discard     <= 1'b1;
                        r_redirect_pc <= BRANCH_target;
                    end
                end
                S_HOLD: begin
                    if (BRANCH_flushIF) begin
                        r_pc    <= BRANCH_target;
                        r_inst  <= NOP;
                        r_fault <= 1'b0;
                    end else if (!r_fault && !FORWARD_stallIF) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch_ysyx23060136.sv
// tb/tb_ifu_fetch_ysyx23060136.sv - self-checking bench for ifu_fetch_ysyx23060136
module tb_ifu_fetch_ysyx23060136;

    localparam logic [31:0] PC0 = 32'h8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int WAIT_START = 0;
    localparam int ASK        = 1;
    localparam int AWAIT      = 2;
    localparam int PRESENT    = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [31:0] target;
    logic        stall;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;

    logic [31:0] IFU_araddr;
    logic        IFU_arvalid;
    logic        IFU_rready;
    logic [31:0] IFU_o_pc;
    logic [31:0] IFU_o_inst;
    logic        IFU_o_valid;
    logic        IFU_o_fault;

    int total = 0;
    int bad   = 0;
    bit armed = 0;
    bit saw_v = 0;

    bit          ar_block   = 0;
    int          r_wait     = 0;
    bit          fault_on   = 0;
    logic [31:0] fault_addr = 32'h0000_0000;

    always #5 clk = ~clk;

    ifu_fetch_ysyx23060136 dut (
        .clk             (clk),
        .rst             (rst),
        .BRANCH_flushIF  (flush),
        .BRANCH_target   (target),
        .FORWARD_stallIF (stall),
        .IFU_araddr      (IFU_araddr),
        .IFU_arvalid     (IFU_arvalid),
        .IFU_arready     (arready),
        .IFU_rdata       (rdata),
        .IFU_rresp       (rresp),
        .IFU_rvalid      (rvalid),
        .IFU_rready      (IFU_rready),
        .IFU_o_pc        (IFU_o_pc),
        .IFU_o_inst      (IFU_o_inst),
        .IFU_o_valid     (IFU_o_valid),
        .IFU_o_fault     (IFU_o_fault)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0093;
        return a ^ 32'h3C3C_0013;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Memory slave: one outstanding read, rvalid r_wait cycles after the address handshake.
    initial begin
        bit          pend;
        bit          stale;
        bit          c_ar;
        bit          c_r;
        int          pcnt;
        logic [31:0] paddr;
        logic [31:0] c_addr;
        pend = 0; stale = 0; c_ar = 0; c_r = 0; pcnt = 0; paddr = 0; c_addr = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            #1;
            if (c_ar) begin pend = 1; stale = 0; paddr = c_addr; pcnt = r_wait; end
            if (c_r) pend = 0;
            if (rst && pend) stale = 1;
            arready = !ar_block && (!pend || stale);
            if (pend && !stale && pcnt > 0) begin
                rvalid = 0;
                pcnt--;
            end else if (pend) begin
                rvalid = 1;
                rdata  = mem(paddr);
                rresp  = (fault_on && paddr == fault_addr) ? 2'd2 : 2'd0;
            end else begin
                rvalid = 0;
            end
            c_ar   = IFU_arvalid && arready && !rst;
            c_addr = IFU_araddr;
            c_r    = rvalid && IFU_rready && !rst;
        end
    end

    // Behavioural model: what the fetch unit is doing, in terms of fetch phases.
    int          m_ph = WAIT_START;
    logic [31:0] m_pc = PC0;
    logic [31:0] m_inst = NOP;
    bit          m_fault = 0;
    bit          m_drop = 0;
    logic [31:0] m_redir = PC0;
    bit          m_f;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = WAIT_START; m_pc = PC0; m_inst = NOP; m_fault = 0; m_drop = 0; m_redir = PC0;
        end else begin
            case (m_ph)
                WAIT_START: begin
                    if (flush) m_pc = target;
                    m_ph = ASK;
                end
                ASK: begin
                    if (flush) begin m_drop = 1; m_redir = target; end
                    if (arready) m_ph = AWAIT;
                end
                AWAIT: begin
                    if (flush) begin m_drop = 1; m_redir = target; end
                    if (rvalid) begin
                        if (m_drop) begin
                            m_pc = m_redir; m_drop = 0; m_ph = ASK;
                        end else begin
                            m_f = 0;
`ifdef IFU_ACCESS_FAULT_EN
                            m_f = fault_on && (m_pc == fault_addr);
`endif
                            m_fault = m_f;
                            m_inst  = m_f ? NOP : mem(m_pc);
                            m_ph    = PRESENT;
                        end
                    end
                end
                default: begin
                    if (flush) begin
                        m_pc = target; m_inst = NOP; m_fault = 0; m_ph = ASK;
                    end else if (!m_fault && !stall) begin
                        m_pc = m_pc + 32'd4; m_ph = ASK;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("arvalid", IFU_arvalid, m_ph == ASK);
            if (m_ph == ASK) chk("araddr", IFU_araddr, m_pc);
            chk("rready", IFU_rready, m_ph == AWAIT);
            chk("o_valid", IFU_o_valid, m_ph == PRESENT);
            if (m_ph == PRESENT) begin
                chk("o_pc", IFU_o_pc, m_pc);
                chk("o_inst", IFU_o_inst, m_inst);
            end
            chk("o_fault", IFU_o_fault, m_fault && m_ph == PRESENT);
        end
    end

    task automatic wait_arvalid(input string nm);
        int n;
        n = 0;
        saw_v = 0;
        do begin
            @(negedge clk);
            if (IFU_o_valid) saw_v = 1;
            n++;
        end while (!IFU_arvalid && n < 50);
        chk({nm, "_arvalid_seen"}, IFU_arvalid, 1);
    endtask

    task automatic wait_ovalid(input string nm);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!IFU_o_valid && n < 50);
        chk({nm, "_ovalid_seen"}, IFU_o_valid, 1);
    endtask

    initial begin
        rst = 1; flush = 0; stall = 0; target = 0;
        @(negedge clk);
        armed = 1;
        @(negedge clk);
        chk("rst_arvalid", IFU_arvalid, 0);
        chk("rst_rready", IFU_rready, 0);
        chk("rst_ovalid", IFU_o_valid, 0);
        chk("rst_fault", IFU_o_fault, 0);
        chk("rst_pc", IFU_araddr, 32'h8000_0000);
        rst = 0;

        // first fetch: AR, R, then HOLD on the third edge after release
        @(negedge clk);
        chk("first_arvalid", IFU_arvalid, 1);
        chk("first_araddr", IFU_araddr, 32'h8000_0000);
        stall = 1;
        @(negedge clk);
        chk("first_rready", IFU_rready, 1);
        @(negedge clk);
        chk("first_ovalid", IFU_o_valid, 1);
        chk("first_inst", IFU_o_inst, 32'h0010_0093);
        chk("first_pc", IFU_o_pc, 32'h8000_0000);

        // stall in HOLD
        repeat (4) @(negedge clk);
        chk("stall_ovalid", IFU_o_valid, 1);
        chk("stall_inst", IFU_o_inst, 32'h0010_0093);
        chk("stall_no_ar", IFU_arvalid, 0);
        stall = 0;
        @(negedge clk);
        chk("after_stall_araddr", IFU_araddr, 32'h8000_0004);

        // flush while in R, data arrives two cycles later and is dropped
        r_wait = 2;
        @(negedge clk);
        chk("r_flush_in_r", IFU_rready, 1);
        flush = 1; target = 32'h8000_0100;
        @(negedge clk);
        flush = 0;
        wait_arvalid("drop");
        chk("drop_no_valid", saw_v, 0);
        chk("drop_araddr", IFU_araddr, 32'h8000_0100);

        // two flushes while arready is low: address stays, last target wins
        ar_block = 1; r_wait = 0;
        flush = 1; target = 32'h8000_0200;
        @(negedge clk);
        target = 32'h8000_0300;
        @(negedge clk);
        flush = 0;
        chk("blk_arvalid", IFU_arvalid, 1);
        chk("blk_araddr", IFU_araddr, 32'h8000_0100);
        @(negedge clk);
        chk("blk_araddr2", IFU_araddr, 32'h8000_0100);
        ar_block = 0;
        wait_arvalid("last_wins");
        chk("last_wins_no_valid", saw_v, 0);
        chk("last_wins_araddr", IFU_araddr, 32'h8000_0300);

        // this fetch completes; next one gets reset while its data is pending
        wait_arvalid("seq");
        chk("seq_araddr", IFU_araddr, 32'h8000_0304);
        r_wait = 1;
        @(negedge clk);
        chk("rst_mid_rready", IFU_rready, 1);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        chk("rst_mid_arvalid", IFU_arvalid, 0);
        chk("rst_mid_rready0", IFU_rready, 0);
        chk("rst_mid_ovalid", IFU_o_valid, 0);
        chk("rst_mid_pc", IFU_araddr, 32'h8000_0000);
        rst = 0; r_wait = 0;
        wait_arvalid("post_rst");
        chk("post_rst_araddr", IFU_araddr, 32'h8000_0000);

        // pc wrap and (optionally) access fault
        stall = 1;
        wait_ovalid("pre_wrap");
        chk("pre_wrap_inst", IFU_o_inst, 32'h0010_0093);
        flush = 1; target = 32'hFFFF_FFFC;
        @(negedge clk);
        flush = 0; stall = 0;
        chk("wrap_araddr0", IFU_araddr, 32'hFFFF_FFFC);
        fault_on = 1; fault_addr = 32'h0000_0000;
        wait_arvalid("wrap");
        chk("wrap_presented", saw_v, 1);
        chk("wrap_araddr", IFU_araddr, 32'h0000_0000);
        wait_ovalid("fault");
`ifdef IFU_ACCESS_FAULT_EN
        chk("fault_flag", IFU_o_fault, 1);
        chk("fault_inst", IFU_o_inst, 32'h0000_0013);
        repeat (3) @(negedge clk);
        chk("fault_held", IFU_o_fault, 1);
        chk("fault_held_valid", IFU_o_valid, 1);
        flush = 1; target = 32'h8000_0000;
        @(negedge clk);
        flush = 0;
        chk("fault_exit_araddr", IFU_araddr, 32'h8000_0000);
`else
        chk("nofault_flag", IFU_o_fault, 0);
        chk("nofault_inst", IFU_o_inst, 32'h3C3C_0013);
`endif
        fault_on = 0;
        repeat (20) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
